// File: rtl/cordic_pkg.sv
// Shared constants and encodings for the CORDIC front end: angle format,
// reducer state encoding and the quadrant code used by shift_region_flag.
package cordic_pkg;

    localparam int W_DEF = 32;
    localparam int F_DEF = 29;

    // round(pi/2 * 2^f); the real-to-integral cast rounds to nearest
    function automatic longint pi_half_q(input int f);
        real r;
        r = 1.5707963267948966;
        for (int i = 0; i < f; i++) r = r * 2.0;
        return longint'(r);
    endfunction

    localparam longint PI_HALF_Q_DEF = pi_half_q(F_DEF);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_REDUCE = ST_REDUCE,
        S_ISSUE  = ST_ISSUE,
        S_WAIT   = ST_WAIT
    } state_t;

    // Quadrant the original angle fell in; decoded by the CORDIC FSM
    localparam logic [1:0] QUAD_I   = 2'd0;
    localparam logic [1:0] QUAD_II  = 2'd1;
    localparam logic [1:0] QUAD_III = 2'd2;
    localparam logic [1:0] QUAD_IV  = 2'd3;

endpackage

// File: rtl/cordic_range_reducer.sv
// Folds a Q3.29 angle into [0, pi/2) one quarter turn per cycle, then hands
// the reduced angle and quadrant to the CORDIC FSM and waits for completion.
module cordic_range_reducer
    import cordic_pkg::*;
#(
    parameter int     W         = W_DEF,
    parameter int     F         = F_DEF,
    parameter longint PI_HALF_Q = pi_half_q(F)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         beg_reduce,
    input  logic [W-1:0] angle_in,
    input  logic         operation,
    input  logic         ready_CORDIC,
    output logic         ready_reduce,
    output logic [W-1:0] angle_out,
    output logic [1:0]   shift_region_flag,
    output logic         operation_out,
    output logic         beg_FSM_CORDIC,
    output logic         range_err
);

    localparam logic signed [W:0] PH = (W+1)'(PI_HALF_Q);

    state_t            state;
    logic signed [W:0] acc;   // working angle carries one guard bit
    logic [1:0]        quad;
    logic [1:0]        step;
    logic              op_q;

    logic adj_neg, adj_pos, need_adj, do_adj;

    always_comb begin
        adj_neg  = acc[W];
        adj_pos  = !acc[W] && (acc >= PH);
        need_adj = adj_neg || adj_pos;
        do_adj   = need_adj && (step != 2'd3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            ready_reduce      <= 1'b1;
            angle_out         <= '0;
            shift_region_flag <= QUAD_I;
            operation_out     <= 1'b0;
            beg_FSM_CORDIC    <= 1'b0;
            range_err         <= 1'b0;
            acc               <= '0;
            quad              <= QUAD_I;
            step              <= '0;
            op_q              <= 1'b0;
        end else begin
            beg_FSM_CORDIC <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (beg_reduce) begin
                        acc          <= {angle_in[W-1], angle_in};
                        quad         <= QUAD_I;
                        step         <= '0;
                        op_q         <= operation;
                        range_err    <= 1'b0;
                        ready_reduce <= 1'b0;
                        state        <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    if (do_adj) begin
                        acc  <= adj_neg ? acc + PH : acc - PH;
                        quad <= adj_neg ? quad - 2'd1 : quad + 2'd1;
                        step <= step + 2'd1;
                    end else begin
                        // out of steps with the angle still out of range: flag it, issue anyway
                        if (need_adj) range_err <= 1'b1;
                        angle_out         <= acc[W-1:0];
                        shift_region_flag <= quad;
                        operation_out     <= op_q;
                        beg_FSM_CORDIC    <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (ready_CORDIC) begin
                        ready_reduce <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Directed vectors for cordic_range_reducer; expected results are queued at
// issue time and checked by an independent monitor on each start pulse.
module tb_cordic_range_reducer;

    logic        clk = 1'b0;
    logic        reset;
    logic        beg_reduce;
    logic [31:0] angle_in;
    logic        operation;
    logic        ready_CORDIC;
    logic        ready_reduce;
    logic [31:0] angle_out;
    logic [1:0]  shift_region_flag;
    logic        operation_out;
    logic        beg_FSM_CORDIC;
    logic        range_err;

    cordic_range_reducer dut (
        .clk              (clk),
        .reset            (reset),
        .beg_reduce       (beg_reduce),
        .angle_in         (angle_in),
        .operation        (operation),
        .ready_CORDIC     (ready_CORDIC),
        .ready_reduce     (ready_reduce),
        .angle_out        (angle_out),
        .shift_region_flag(shift_region_flag),
        .operation_out    (operation_out),
        .beg_FSM_CORDIC   (beg_FSM_CORDIC),
        .range_err        (range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [1:0]  f;
        logic        op;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (beg_FSM_CORDIC) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("angle_out", angle_out, e.a);
                chk("shift_region_flag", 32'(shift_region_flag), 32'(e.f));
                chk("operation_out", 32'(operation_out), 32'(e.op));
                chk("range_err", 32'(range_err), 32'd0);
                chk("pulse_latency", cyc, e.due);
            end
        end
    end

    // One request through the full handshake. ready_CORDIC is pulsed during
    // ISSUE (must be ignored) and again on the third WAIT cycle.
    task automatic run_op(input logic [31:0] a, input logic op, input logic [31:0] ea,
                          input logic [1:0] ef, input int n, input bit hold);
        exp_t e;
        int   t;
        t = 0;
        while (!ready_reduce && t < 50) begin @(negedge clk); t++; end
        chk("ready_before_capture", 32'(ready_reduce), 32'd1);
        angle_in   = a;
        operation  = op;
        beg_reduce = 1'b1;
        e.a = ea; e.f = ef; e.op = op; e.due = cyc + n + 2;
        sb.push_back(e);
        @(negedge clk);
        chk("ready_drop", 32'(ready_reduce), 32'd0);
        if (!hold) beg_reduce = 1'b0;
        t = 0;
        while (!beg_FSM_CORDIC && t < 20) begin @(negedge clk); t++; end
        chk("pulse_seen", 32'(beg_FSM_CORDIC), 32'd1);
        ready_CORDIC = 1'b1;
        @(negedge clk);
        ready_CORDIC = 1'b0;
        chk("pulse_one_cycle", 32'(beg_FSM_CORDIC), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            chk("wait_ready_low", 32'(ready_reduce), 32'd0);
            chk("wait_angle_hold", angle_out, ea);
            chk("wait_flag_hold", 32'(shift_region_flag), 32'(ef));
            if (i < 3) @(negedge clk);
        end
        ready_CORDIC = 1'b1;
        @(negedge clk);
        ready_CORDIC = 1'b0;
        chk("ready_rise", 32'(ready_reduce), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        beg_reduce   = 1'b0;
        angle_in     = '0;
        operation    = 1'b0;
        ready_CORDIC = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(ready_reduce), 32'd1);
        chk("rst_angle", angle_out, 32'd0);
        chk("rst_flag", 32'(shift_region_flag), 32'd0);
        chk("rst_op", 32'(operation_out), 32'd0);
        chk("rst_beg", 32'(beg_FSM_CORDIC), 32'd0);
        chk("rst_err", 32'(range_err), 32'd0);
        @(negedge clk);

        run_op(32'h1000_0000, 1'b1, 32'h1000_0000, 2'd0, 0, 1'b0);  // 0.5, no step
        run_op(32'd1073741824, 1'b0, 32'd230426967, 2'd1, 1, 1'b0);  // 2.0 - pi/2
        run_op(-32'sd536870912, 1'b1, 32'd306443945, 2'd3, 1, 1'b0); // -1.0 + pi/2
        // -4.0 + 3*843314857 = 382460923
        run_op(32'h8000_0000, 1'b0, 32'd382460923, 2'd1, 3, 1'b0);
        run_op(32'h7000_0000, 1'b1, 32'd192418478, 2'd2, 2, 1'b0);   // 3.5 - pi
        run_op(32'd843314857, 1'b0, 32'd0, 2'd1, 1, 1'b0);           // exactly pi/2
        run_op(32'd843314856, 1'b1, 32'd843314856, 2'd0, 0, 1'b0);   // just below pi/2

        // beg_reduce held through WAIT: the collision cycle only returns to
        // IDLE, the held request is captured on the following edge
        run_op(32'd1073741824, 1'b1, 32'd230426967, 2'd1, 1, 1'b1);
        chk("collision_still_req", 32'(beg_reduce), 32'd1);
        run_op(32'd1073741824, 1'b1, 32'd230426967, 2'd1, 1, 1'b0);

        // reset on the first REDUCE cycle aborts with no start pulse
        angle_in   = 32'd1073741824;
        operation  = 1'b1;
        beg_reduce = 1'b1;
        @(negedge clk);
        beg_reduce = 1'b0;
        chk("abort_in_reduce", 32'(ready_reduce), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(ready_reduce), 32'd1);
        chk("abort_angle", angle_out, 32'd0);
        chk("abort_flag", 32'(shift_region_flag), 32'd0);
        chk("abort_op", 32'(operation_out), 32'd0);
        chk("abort_beg", 32'(beg_FSM_CORDIC), 32'd0);
        chk("abort_err", 32'(range_err), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", 32'(ready_reduce), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
